// File: rtl/flappy_geom_pkg.sv
// ---------------------------------------------------------------------------
// flappy_geom_pkg
// Shared screen and sprite geometry for the Flappy pipe stages, plus the
// play-state enum used by every pipe motion block.
// Contents:
//   PIPE_W, PIPE_H   pipe sprite size in pixels
//   GAP_PIPE         vertical gap between upper and lower pipe
//   MAX_Y, SCREEN_W  playfield limits
//   BIRD_X           bird column used for scoring
//   coord_t          10-bit unsigned screen coordinate
//   pipe_state_e     IDLE / RUN / HALT
//   pipe_top()       top edge of an upper pipe from its bottom edge
// ---------------------------------------------------------------------------
package flappy_geom_pkg;

    localparam int unsigned PIPE_W   = 41;
    localparam int unsigned PIPE_H   = 253;
    localparam int unsigned GAP_PIPE = 70;
    localparam int unsigned MAX_Y    = 426;
    localparam int unsigned SCREEN_W = 640;
    localparam int unsigned BIRD_X   = 200;

    typedef logic [9:0] coord_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } pipe_state_e;

    // The sprite hangs from the bottom edge; when it would poke above the
    // screen the top edge clamps to row 0.
    function automatic coord_t pipe_top(input coord_t bottom);
        coord_t span;
        span = coord_t'(PIPE_H - 1);
        return (bottom >= span) ? coord_t'(bottom - span) : coord_t'(0);
    endfunction

endpackage

// File: rtl/pipe_lfsr.sv
// ---------------------------------------------------------------------------
// pipe_lfsr
// 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1, free running.
// Each pipe pair instantiates its own copy with a different SEED so the
// heights of the pairs are decorrelated.
// Ports:
//   clk_i        clock
//   rst_i        asynchronous active-high reset, loads SEED
//   rand_byte_o  low byte of the current LFSR state
// ---------------------------------------------------------------------------
module pipe_lfsr #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    output logic [7:0] rand_byte_o
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    // Taps at bits 16,14,13,11 (1-based) map to indices 15,13,12,10.
    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign rand_byte_o = lfsr_q[7:0];

endmodule

// File: rtl/pipe_one_high_move.sv
// ---------------------------------------------------------------------------
// pipe_one_high_move
// Motion and height generator for the upper pipe of pipe pair one. Scrolls
// the pipe left by STEP on every game tick, respawns it at the right edge
// with a pseudo-random bottom edge, and pulses scored when the pipe passes
// the bird column. All outputs are registered.
// Ports:
//   system_clk  sole clock
//   reset       asynchronous active-high reset
//   game_tick   one-cycle move strobe
//   start       one-cycle strobe: begin or restart play
//   crash       one-cycle strobe from collision logic: freeze
//   pipe_pic_l  left x        pipe_pic_r  right x
//   pipe_pic_t  top y         pipe_pic_b  bottom y
//   scored      one-cycle pulse when the pipe's right edge passes BIRD_X
//   running     high while in RUN
// ---------------------------------------------------------------------------
module pipe_one_high_move
    import flappy_geom_pkg::*;
#(
    parameter int unsigned SPAWN_X = 640,
    parameter int unsigned STEP    = 2,
    parameter int unsigned MIN_B   = 40,
    parameter int unsigned INIT_B  = 150,
    parameter logic [15:0] SEED    = 16'hACE1
) (
    input  logic       system_clk,
    input  logic       reset,
    input  logic       game_tick,
    input  logic       start,
    input  logic       crash,
    output logic [9:0] pipe_pic_l,
    output logic [9:0] pipe_pic_r,
    output logic [9:0] pipe_pic_t,
    output logic [9:0] pipe_pic_b,
    output logic       scored,
    output logic       running
);

    localparam coord_t SPAWN_C  = coord_t'(SPAWN_X);
    localparam coord_t STEP_C   = coord_t'(STEP);
    localparam coord_t MIN_B_C  = coord_t'(MIN_B);
    localparam coord_t INIT_B_C = coord_t'(INIT_B);
    localparam coord_t WIDTH_C  = coord_t'(PIPE_W - 1);
    localparam coord_t BIRD_C   = coord_t'(BIRD_X);

    logic [7:0]  rand_byte;
    pipe_state_e state_q, state_d;
    coord_t      l_q, l_d;
    coord_t      r_q, r_d;
    coord_t      t_q, t_d;
    coord_t      b_q, b_d;
    logic        scored_q, scored_d;
    logic        running_q, running_d;
    coord_t      new_b;
    coord_t      moved_l;
    coord_t      moved_r;

    pipe_lfsr #(
        .SEED(SEED)
    ) u_lfsr (
        .clk_i      (system_clk),
        .rst_i      (reset),
        .rand_byte_o(rand_byte)
    );

    // Respawn height always lies in MIN_B..MIN_B+255, keeping the lower
    // pipe's top edge on screen.
    assign new_b   = MIN_B_C + {2'b00, rand_byte};
    assign moved_l = l_q - STEP_C;
    assign moved_r = moved_l + WIDTH_C;

    always_comb begin
        state_d  = state_q;
        l_d      = l_q;
        b_d      = b_q;
        scored_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                // crash takes priority over a tick on the same cycle
                if (crash) begin
                    state_d = HALT;
                end else if (game_tick) begin
                    // l <= STEP also guards the subtraction against wrap
                    if (l_q <= STEP_C) begin
                        l_d = SPAWN_C;
                        b_d = new_b;
                    end else begin
                        l_d = moved_l;
                        if ((r_q >= BIRD_C) && (moved_r < BIRD_C)) begin
                            scored_d = 1'b1;
                        end
                    end
                end
            end
            HALT: begin
                if (start) begin
                    state_d = RUN;
                    l_d     = SPAWN_C;
                    b_d     = new_b;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        r_d       = l_d + WIDTH_C;
        t_d       = pipe_top(b_d);
        running_d = (state_d == RUN);
    end

    always_ff @(posedge system_clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            l_q       <= SPAWN_C;
            r_q       <= SPAWN_C + WIDTH_C;
            t_q       <= pipe_top(INIT_B_C);
            b_q       <= INIT_B_C;
            scored_q  <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            l_q       <= l_d;
            r_q       <= r_d;
            t_q       <= t_d;
            b_q       <= b_d;
            scored_q  <= scored_d;
            running_q <= running_d;
        end
    end

    assign pipe_pic_l = l_q;
    assign pipe_pic_r = r_q;
    assign pipe_pic_t = t_q;
    assign pipe_pic_b = b_q;
    assign scored     = scored_q;
    assign running    = running_q;

endmodule

// File: tb/tb_pipe_one_high_move.sv
// ---------------------------------------------------------------------------
// tb_pipe_one_high_move
// Scoreboard bench for pipe_one_high_move. Every driven cycle pushes the
// reference model's expected outputs; the entry is popped and compared one
// cycle later when the registered outputs appear.
// ---------------------------------------------------------------------------
module tb_pipe_one_high_move;

    localparam int pipeW  = 41;
    localparam int pipeH  = 253;
    localparam int spawnX = 640;
    localparam int stepPx = 2;
    localparam int birdX  = 200;
    localparam int minB   = 40;
    localparam int initB  = 150;

    typedef struct packed {
        logic [9:0] l;
        logic [9:0] r;
        logic [9:0] t;
        logic [9:0] b;
        logic       scored;
        logic       running;
    } obs_t;

    logic       system_clk = 1'b0;
    logic       reset      = 1'b1;
    logic       game_tick  = 1'b0;
    logic       start      = 1'b0;
    logic       crash      = 1'b0;
    logic [9:0] pipe_pic_l;
    logic [9:0] pipe_pic_r;
    logic [9:0] pipe_pic_t;
    logic [9:0] pipe_pic_b;
    logic       scored;
    logic       running;

    obs_t        sb[$];
    obs_t        got;
    obs_t        exp;
    int          nChecks = 0;
    int          nFail   = 0;
    int          mState;
    int          mL;
    int          mB;
    logic [15:0] mLfsr;

    pipe_one_high_move dut (
        .system_clk(system_clk),
        .reset     (reset),
        .game_tick (game_tick),
        .start     (start),
        .crash     (crash),
        .pipe_pic_l(pipe_pic_l),
        .pipe_pic_r(pipe_pic_r),
        .pipe_pic_t(pipe_pic_t),
        .pipe_pic_b(pipe_pic_b),
        .scored    (scored),
        .running   (running)
    );

    always #5 system_clk = ~system_clk;

    function automatic int topOf(input int b);
        return (b >= pipeH - 1) ? b - (pipeH - 1) : 0;
    endfunction

    function automatic obs_t sampleDut();
        return {pipe_pic_l, pipe_pic_r, pipe_pic_t, pipe_pic_b, scored, running};
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("l=%0d r=%0d t=%0d b=%0d scored=%0b running=%0b",
                         o.l, o.r, o.t, o.b, o.scored, o.running);
    endfunction

    task automatic modelReset();
        mState = 0;
        mL     = spawnX;
        mB     = initB;
        mLfsr  = 16'hACE1;
        sb.delete();
    endtask

    // Drives one cycle of strobes and pushes what the outputs must be after
    // the sampling edge. State 0=idle, 1=run, 2=halt.
    task automatic drive(input logic tick, input logic st, input logic cr);
        obs_t e;
        int   oldR;
        int   nb;
        logic sc;
        @(negedge system_clk);
        game_tick = tick;
        start     = st;
        crash     = cr;
        sc        = 1'b0;
        nb        = minB + int'(mLfsr[7:0]);
        case (mState)
            0: if (st) mState = 1;
            1: begin
                if (cr) begin
                    mState = 2;
                end else if (tick) begin
                    if (mL <= stepPx) begin
                        mL = spawnX;
                        mB = nb;
                    end else begin
                        oldR = mL + pipeW - 1;
                        mL   = mL - stepPx;
                        if (oldR >= birdX && (mL + pipeW - 1) < birdX) sc = 1'b1;
                    end
                end
            end
            2: if (st) begin
                mState = 1;
                mL     = spawnX;
                mB     = nb;
            end
            default: ;
        endcase
        e.l       = 10'(mL);
        e.r       = 10'(mL + pipeW - 1);
        e.t       = 10'(topOf(mB));
        e.b       = 10'(mB);
        e.scored  = sc;
        e.running = (mState == 1);
        sb.push_back(e);
        mLfsr = {mLfsr[14:0], mLfsr[15] ^ mLfsr[13] ^ mLfsr[12] ^ mLfsr[10]};
        @(posedge system_clk);
        #1;
        game_tick = 1'b0;
        start     = 1'b0;
        crash     = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge system_clk);
        #1;
        reset = 1'b0;
        modelReset();
        drive(1'b0, 1'b1, 1'b0);
        got = sampleDut(); exp = sb.pop_front(); nChecks++;
        if (got !== exp) begin
            nFail++;
            $display("[TB] FAIL reset_start got %s expected %s", fmt(got), fmt(exp));
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            got = sampleDut(); exp = sb.pop_front(); nChecks++;
            if (got !== exp) begin
                nFail++;
                $display("[TB] FAIL reset_premove got %s expected %s", fmt(got), fmt(exp));
            end
        end
        // assert reset between clock edges and look before the next edge
        reset = 1'b1;
        #2;
        got = sampleDut();
        exp = '{l:10'd640, r:10'd680, t:10'd0, b:10'd150, scored:1'b0, running:1'b0};
        nChecks++;
        if (got !== exp) begin
            nFail++;
            $display("[TB] FAIL reset_async got %s expected %s", fmt(got), fmt(exp));
        end
        @(posedge system_clk);
        #1;
        reset = 1'b0;
        modelReset();
    endtask

    task automatic test_idle_tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            got = sampleDut(); exp = sb.pop_front(); nChecks++;
            if (got !== exp) begin
                nFail++;
                $display("[TB] FAIL idle_tick got %s expected %s", fmt(got), fmt(exp));
            end
        end
        nChecks++;
        if (got.l !== 10'd640 || got.running !== 1'b0) begin
            nFail++;
            $display("[TB] FAIL idle_hold got l=%0d running=%0b expected l=640 running=0",
                     got.l, got.running);
        end
    endtask

    task automatic test_start_and_move();
        drive(1'b0, 1'b1, 1'b0);
        got = sampleDut(); exp = sb.pop_front(); nChecks++;
        if (got !== exp) begin
            nFail++;
            $display("[TB] FAIL start got %s expected %s", fmt(got), fmt(exp));
        end
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            got = sampleDut(); exp = sb.pop_front(); nChecks++;
            if (got !== exp) begin
                nFail++;
                $display("[TB] FAIL move_tick got %s expected %s", fmt(got), fmt(exp));
            end
            drive(1'b0, 1'b0, 1'b0);
            got = sampleDut(); exp = sb.pop_front(); nChecks++;
            if (got !== exp) begin
                nFail++;
                $display("[TB] FAIL move_gap got %s expected %s", fmt(got), fmt(exp));
            end
        end
        exp = '{l:10'd620, r:10'd660, t:10'd0, b:10'd150, scored:1'b0, running:1'b1};
        nChecks++;
        if (got !== exp) begin
            nFail++;
            $display("[TB] FAIL ten_ticks got %s expected %s", fmt(got), fmt(exp));
        end
    endtask

    task automatic test_start_in_run();
        drive(1'b0, 1'b1, 1'b0);
        got = sampleDut(); exp = sb.pop_front(); nChecks++;
        if (got !== exp) begin
            nFail++;
            $display("[TB] FAIL start_in_run got %s expected %s", fmt(got), fmt(exp));
        end
        nChecks++;
        if (got.l !== 10'd620 || got.running !== 1'b1) begin
            nFail++;
            $display("[TB] FAIL start_in_run_hold got l=%0d running=%0b expected l=620 running=1",
                     got.l, got.running);
        end
    endtask

    task automatic test_score_crossing();
        int pulses = 0;
        int pulseL = -1;
        int budget = 0;
        while (mL > 154 && budget < 400) begin
            budget++;
            drive(1'b1, 1'b0, 1'b0);
            got = sampleDut(); exp = sb.pop_front(); nChecks++;
            if (got !== exp) begin
                nFail++;
                $display("[TB] FAIL score_walk got %s expected %s", fmt(got), fmt(exp));
            end
            if (got.scored === 1'b1) begin
                pulses++;
                pulseL = int'(got.l);
            end
        end
        nChecks++;
        if (pulses != 1 || pulseL != 158) begin
            nFail++;
            $display("[TB] FAIL score_once got pulses=%0d at l=%0d expected pulses=1 at l=158",
                     pulses, pulseL);
        end
    endtask

    task automatic test_respawn();
        int budget = 0;
        while (mL > stepPx && budget < 400) begin
            budget++;
            drive(1'b1, 1'b0, 1'b0);
            got = sampleDut(); exp = sb.pop_front(); nChecks++;
            if (got !== exp) begin
                nFail++;
                $display("[TB] FAIL respawn_walk got %s expected %s", fmt(got), fmt(exp));
            end
        end
        drive(1'b1, 1'b0, 1'b0);
        got = sampleDut(); exp = sb.pop_front(); nChecks++;
        if (got !== exp) begin
            nFail++;
            $display("[TB] FAIL respawn got %s expected %s", fmt(got), fmt(exp));
        end
        nChecks++;
        if (got.l !== 10'd640 || got.r !== 10'd680 || got.b < 10'd40 || got.b > 10'd295
            || got.scored !== 1'b0) begin
            nFail++;
            $display("[TB] FAIL respawn_bounds got %s expected l=640 r=680 b in 40..295 scored=0",
                     fmt(got));
        end
    endtask

    task automatic test_crash();
        int budget = 0;
        while (mL > 300 && budget < 400) begin
            budget++;
            drive(1'b1, 1'b0, 1'b0);
            got = sampleDut(); exp = sb.pop_front(); nChecks++;
            if (got !== exp) begin
                nFail++;
                $display("[TB] FAIL crash_walk got %s expected %s", fmt(got), fmt(exp));
            end
        end
        drive(1'b1, 1'b0, 1'b1);
        got = sampleDut(); exp = sb.pop_front(); nChecks++;
        if (got !== exp) begin
            nFail++;
            $display("[TB] FAIL crash_with_tick got %s expected %s", fmt(got), fmt(exp));
        end
        nChecks++;
        if (got.l !== 10'd300 || got.running !== 1'b0) begin
            nFail++;
            $display("[TB] FAIL crash_halt got l=%0d running=%0b expected l=300 running=0",
                     got.l, got.running);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, (i == 2));
            got = sampleDut(); exp = sb.pop_front(); nChecks++;
            if (got !== exp) begin
                nFail++;
                $display("[TB] FAIL halt_tick got %s expected %s", fmt(got), fmt(exp));
            end
        end
        nChecks++;
        if (got.l !== 10'd300) begin
            nFail++;
            $display("[TB] FAIL halt_frozen got l=%0d expected l=300", got.l);
        end
    endtask

    // Waits in HALT until the model LFSR offers low byte 220, so the restart
    // lands at b=260, an upper pipe tall enough that its top is not clamped.
    task automatic test_halt_restart();
        int budget = 0;
        while (mLfsr[7:0] != 8'd220 && budget < 5000) begin
            budget++;
            drive(1'b0, 1'b0, 1'b0);
            got = sampleDut(); exp = sb.pop_front(); nChecks++;
            if (got !== exp) begin
                nFail++;
                $display("[TB] FAIL halt_wait got %s expected %s", fmt(got), fmt(exp));
            end
        end
        if (mLfsr[7:0] != 8'd220) begin
            nChecks++;
            nFail++;
            $display("[TB] FAIL halt_wait_budget got byte=%0d expected 220", mLfsr[7:0]);
        end
        drive(1'b0, 1'b1, 1'b0);
        got = sampleDut(); exp = sb.pop_front(); nChecks++;
        if (got !== exp) begin
            nFail++;
            $display("[TB] FAIL halt_restart got %s expected %s", fmt(got), fmt(exp));
        end
        exp = '{l:10'd640, r:10'd680, t:10'd8, b:10'd260, scored:1'b0, running:1'b1};
        nChecks++;
        if (got !== exp) begin
            nFail++;
            $display("[TB] FAIL tall_pipe got %s expected %s", fmt(got), fmt(exp));
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            got = sampleDut(); exp = sb.pop_front(); nChecks++;
            if (got !== exp) begin
                nFail++;
                $display("[TB] FAIL after_restart got %s expected %s", fmt(got), fmt(exp));
            end
        end
    endtask

    initial begin
        $display("[TB] starting pipe_one_high_move bench");
        test_reset();
        test_idle_tick();
        test_start_and_move();
        test_start_in_run();
        test_score_crossing();
        test_respawn();
        test_crash();
        test_halt_restart();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
